// File: rtl/seq_addsub_cmp_pkg.sv
// Shared op encodings and FSM state type for the sliced add/subtract/compare unit.
package seq_addsub_cmp_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_ADDC = 2'b10;
    localparam logic [1:0] OP_CMP  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic logic is_sub(input logic [1:0] op);
        return (op == OP_SUB) || (op == OP_CMP);
    endfunction

endpackage

// File: rtl/seq_addsub_cmp_chunk_adder.sv
// Combinational CHUNK-bit ripple adder; the top reuses one instance for every slice.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o
);

    logic [CHUNK:0] c;

    always_comb begin
        c     = '0;
        sum_o = '0;
        c[0]  = cin_i;
        for (int i = 0; i < CHUNK; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
        cout_o = c[CHUNK];
    end

endmodule

// File: rtl/seq_addsub_cmp.sv
// Multi-cycle add/sub/compare, one CHUNK slice per clock with rippled carry.
// Result flags exist only when SEQ_ADDSUB_CMP_FLAGS_EN is defined; otherwise they read 0.
//   state   | meaning
//   IDLE    | waiting for start
//   RUN     | adding slice idx_q, NCHUNK cycles
//   DONE    | done pulse; start here chains straight into RUN
module seq_addsub_cmp
    import seq_addsub_cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             lt_u,
    output logic             lt_s
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if ((WIDTH % CHUNK) != 0) begin : g_width_check
        $error("seq_addsub_cmp: WIDTH must be a multiple of CHUNK");
    end

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             load, finish;
    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;

    chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .a_i    (a_q[int'(idx_q)*CHUNK +: CHUNK]),
        .b_i    (b_q[int'(idx_q)*CHUNK +: CHUNK]),
        .cin_i  (carry_q),
        .sum_o  (slice_sum),
        .cout_o (slice_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        diff_d  = diff_q;
        load    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE: load = start;
            ST_RUN: begin
                diff_d[int'(idx_q)*CHUNK +: CHUNK] = slice_sum;
                carry_d = slice_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IW'(NCHUNK - 1)) begin
                    state_d = ST_DONE;
                    finish  = 1'b1;
                end
            end
            ST_DONE: begin
                load    = start;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            state_d = ST_RUN;
            a_d     = A;
            b_d     = is_sub(op) ? ~B : B;
            op_d    = op;
            idx_d   = '0;
            diff_d  = '0;
            case (op)
                OP_ADD:  carry_d = 1'b0;
                OP_ADDC: carry_d = carry_in;
                default: carry_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            diff_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            diff_q  <= diff_d;
            if (finish) begin
                cout_q <= slice_cout;
                if (op_q != OP_CMP) sum_q <= diff_d;
            end
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign Sum  = sum_q;
    assign Cout = cout_q;

`ifdef SEQ_ADDSUB_CMP_FLAGS_EN
    logic zero_q, neg_q, ovf_q, lt_u_q, lt_s_q;
    logic ovf_d;

    // Overflow uses the stored B', so SUB/CMP see the inverted operand sign.
    assign ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
            lt_u_q <= 1'b0;
            lt_s_q <= 1'b0;
        end else if (finish) begin
            zero_q <= (diff_d == '0);
            neg_q  <= diff_d[WIDTH-1];
            ovf_q  <= ovf_d;
            lt_u_q <= is_sub(op_q) & ~slice_cout;
            lt_s_q <= is_sub(op_q) & (diff_d[WIDTH-1] ^ ovf_d);
        end
    end

    assign zero = zero_q;
    assign neg  = neg_q;
    assign ovf  = ovf_q;
    assign lt_u = lt_u_q;
    assign lt_s = lt_s_q;
`else
    assign zero = 1'b0;
    assign neg  = 1'b0;
    assign ovf  = 1'b0;
    assign lt_u = 1'b0;
    assign lt_s = 1'b0;
`endif

endmodule

// File: doc/seq_addsub_cmp.md
# seq_addsub_cmp

Multi-cycle, parametrised add/subtract/compare unit for the datapath ALU. It processes WIDTH-bit operands in CHUNK-bit slices, one slice per clock, using a ripple carry between slices. It supports ADD, ADD-with-carry, SUB (two's-complement A + ~B + 1) and CMP (subtract for flags only). It returns the result and a full flag set through a start/busy/done handshake, and replaces the single-cycle 16-bit subtract-as-compare path where a shorter critical path is needed.

## Interface
Parameters:
- WIDTH, 16: operand and result width; must be a multiple of CHUNK, otherwise elaboration fails.
- CHUNK, 4: slice width processed per cycle; NCHUNK = WIDTH/CHUNK.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request; sampled only when the unit can accept.
- op  in  2  00 ADD, 01 SUB, 10 ADDC, 11 CMP.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- carry_in  in  1  carry input; used by ADDC only.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result and flags are valid.
- Sum  out  WIDTH  result; held until the next completing non-CMP operation.
- Cout  out  1  carry out of the MSB; for SUB/CMP, 1 means no borrow.
- zero, neg, ovf  out  1 each  result flags.
- lt_u, lt_s  out  1 each  compare flags.

## Operation
- States:
  - IDLE: start=1 captures A, B, op, carry_in, clears the slice index and goes to RUN.
  - RUN: for NCHUNK cycles; each cycle adds slice k of A and of B' (B' = ~B for SUB/CMP, B otherwise), plus the carry from slice k-1, into an internal diff register. Slice 0 carry-in is 0 for ADD, 1 for SUB/CMP, and carry_in for ADDC.
  - After the last slice, go to DONE.
  - DONE: done=1 for exactly one cycle. If start=1, go directly to RUN (back-to-back); otherwise go to IDLE.
- Sum is updated from diff in the DONE transition, except for CMP. CMP leaves Sum unchanged and updates only the flags.
- Flags are computed from the full WIDTH-bit diff:
  - zero = (diff == 0)
  - neg = diff[MSB]
  - ovf = signed overflow (operand MSBs equal, result MSB different, with B' used for SUB/CMP)
  - lt_u = ~Cout for SUB/CMP, 0 otherwise
  - lt_s = neg ^ ovf for SUB/CMP, 0 otherwise
- Arithmetic is modulo 2^WIDTH; there is no saturation.
- start while busy=1 is ignored; operand changes during RUN have no effect.
- Reset at any point, including mid-RUN, returns the unit to IDLE and discards the in-flight operation.

## Timing
- Reset values: busy=0, done=0, Sum=0, Cout=0, all flags 0; internal diff, index and carry cleared.
- Latency: start is sampled high in cycle 0, busy is high in cycles 1..NCHUNK, and done is high in cycle NCHUNK+1. For WIDTH=16, CHUNK=4, done is high in cycle 5.
- Throughput: one operation per NCHUNK+1 cycles when start is held high through the DONE cycle.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- SEQ_ADDSUB_CMP_FLAGS_EN defined: zero, neg, ovf, lt_u and lt_s are computed and registered as described above.
- Not defined: these five outputs are tied to 0 and their logic is removed. Sum, Cout and the handshake are unaffected.

## Structure
- Package seq_addsub_cmp_pkg holds:
  - the op encoding constants (OP_ADD, OP_SUB, OP_ADDC, OP_CMP);
  - the state typedef (ST_IDLE, ST_RUN, ST_DONE).
- One sub-module, chunk_adder: a combinational CHUNK-bit ripple adder with cin/cout, instantiated once and reused each RUN cycle on the selected slice.

## Test plan
All scenarios use WIDTH=16, CHUNK=4, with the macro defined unless stated.

- SUB A=0x0005, B=0x0003 → done in cycle 5; Sum=0x0002, Cout=1, zero=0, neg=0, lt_u=0, lt_s=0.
- CMP A=0x0003, B=0x0005 after the previous test → Sum stays 0x0002; Cout=0, neg=1, ovf=0, lt_u=1, lt_s=1.
- SUB A=0x8000, B=0x0001 → Sum=0x7FFF, ovf=1, neg=0, lt_s=1, lt_u=0, Cout=1.
- ADD A=0xFFFF, B=0x0001 → Sum=0x0000, Cout=1, zero=1, ovf=0.
- ADDC A=0x00FF, B=0x0000, carry_in=1 → Sum=0x0100.
- Handshake and reset, then macro off:
  - start pulses during busy are ignored.
  - Asserting reset in cycle 2 of an operation gives busy=0, done never pulses, Sum=0.
  - start held through DONE gives a second done exactly 5 cycles later.
  - With the macro undefined, all five flags read 0 in every scenario.
